// File: rtl/packing_collector.sv
// Packs a packet stream of DATA_WIDTH-bit items into ITEM_COUNT-slot words with a keep mask.
// A packet tail shorter than ITEM_COUNT is flushed as a partial word, and its unused slots hold PAD_VALUE.
module packing_collector #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ITEM_COUNT     = 3,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE      = '0,
    parameter bit                    FIRST_ITEM_MSB = 1'b0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    output logic [DATA_WIDTH*ITEM_COUNT-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [ITEM_COUNT-1:0]            out_keep
);

    localparam int CW = (ITEM_COUNT > 1) ? $clog2(ITEM_COUNT) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(ITEM_COUNT - 1);

    logic [ITEM_COUNT-1:0][DATA_WIDTH-1:0] acc_reg;
    logic [ITEM_COUNT-1:0]                 keep_reg;
    logic [CW-1:0]                         count_reg;

    logic [DATA_WIDTH*ITEM_COUNT-1:0]      out_data_reg;
    logic [ITEM_COUNT-1:0]                 out_keep_reg;
    logic                                  out_valid_reg;
    logic                                  out_last_reg;

    logic                                  in_fire;
    logic                                  completing;
    logic [ITEM_COUNT-1:0]                 slot_hit;
    logic [ITEM_COUNT-1:0][DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH*ITEM_COUNT-1:0]      word_next;

    assign in_ready   = !out_valid_reg || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign completing = in_fire && (in_last || (count_reg == LAST_SLOT));

    // merged is the accumulator with the incoming item already written into slot[count].
    // Slot order is fixed here; only the bit position of each slot in the word depends on FIRST_ITEM_MSB.
    generate
        for (genvar gi = 0; gi < ITEM_COUNT; gi++) begin : g_slot
            localparam int POS = FIRST_ITEM_MSB ? (ITEM_COUNT - 1 - gi) : gi;
            assign slot_hit[gi] = (count_reg == CW'(gi));
            assign merged[gi]   = slot_hit[gi] ? in_data : acc_reg[gi];
            assign word_next[POS*DATA_WIDTH +: DATA_WIDTH] = merged[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg       <= {ITEM_COUNT{PAD_VALUE}};
            keep_reg      <= '0;
            count_reg     <= '0;
            out_data_reg  <= {ITEM_COUNT{PAD_VALUE}};
            out_keep_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // A completing item overrides the drain, so back-to-back words keep out_valid high.
            if (completing) begin
                out_data_reg  <= word_next;
                out_keep_reg  <= keep_reg | slot_hit;
                out_last_reg  <= in_last;
                out_valid_reg <= 1'b1;
                acc_reg       <= {ITEM_COUNT{PAD_VALUE}};
                keep_reg      <= '0;
                count_reg     <= '0;
            end else if (in_fire) begin
                acc_reg   <= merged;
                keep_reg  <= keep_reg | slot_hit;
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_packing_collector.sv
// Directed bench for packing_collector: LSB-first (a) and MSB-first padded (b) instances with 3-slot words,
// plus a 1-slot instance (c) that is checked against a scoreboard under random stalls on both sides.
module tb_packing_collector;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0]  a_in_data, b_in_data, c_in_data;
    logic        a_in_valid, b_in_valid, c_in_valid;
    logic        a_in_ready, b_in_ready, c_in_ready;
    logic        a_in_last, b_in_last, c_in_last;
    logic [23:0] a_out_data, b_out_data;
    logic [7:0]  c_out_data;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic        a_out_ready, b_out_ready, c_out_ready;
    logic        a_out_last, b_out_last, c_out_last;
    logic [2:0]  a_out_keep, b_out_keep;
    logic [0:0]  c_out_keep;

    packing_collector #(.DATA_WIDTH(8), .ITEM_COUNT(3), .PAD_VALUE(8'h00), .FIRST_ITEM_MSB(1'b0)) dut_a (
        .clock(clock), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(a_in_last),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .out_keep(a_out_keep)
    );

    packing_collector #(.DATA_WIDTH(8), .ITEM_COUNT(3), .PAD_VALUE(8'hEE), .FIRST_ITEM_MSB(1'b1)) dut_b (
        .clock(clock), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .out_keep(b_out_keep)
    );

    packing_collector #(.DATA_WIDTH(8), .ITEM_COUNT(1), .PAD_VALUE(8'h00), .FIRST_ITEM_MSB(1'b0)) dut_c (
        .clock(clock), .reset(reset),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_last(c_in_last),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_last(c_out_last), .out_keep(c_out_keep)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic v, input logic [23:0] d, input logic [2:0] k,
                            input logic l, input logic [23:0] exp_d, input logic [2:0] exp_k, input logic exp_l);
        $display("word %s: valid=%b data=%h keep=%b last=%b", tag, v, d, k, l);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_data"},  32'(d), 32'(exp_d));
        chk({tag, "_keep"},  32'(k), 32'(exp_k));
        chk({tag, "_last"},  32'(l), 32'(exp_l));
    endtask

    task automatic a_drive(input logic v, input logic [7:0] d, input logic l);
        a_in_valid = v; a_in_data = d; a_in_last = l;
    endtask

    task automatic b_drive(input logic v, input logic [7:0] d, input logic l);
        b_in_valid = v; b_in_data = d; b_in_last = l;
    endtask

    // Scoreboard for the 1-slot instance; transfers are sampled mid-cycle, away from the clock edge.
    localparam int C_ITEMS = 40;
    logic [8:0] c_q[$];
    logic [8:0] c_exp;
    bit         c_fired = 1'b0;
    int         c_recv  = 0;

    always @(negedge clock) begin
        if (c_in_valid && c_in_ready) begin
            c_q.push_back({c_in_last, c_in_data});
            c_fired = 1'b1;
        end
        if (c_out_valid && c_out_ready) begin
            $display("c out: data=%h keep=%b last=%b", c_out_data, c_out_keep, c_out_last);
            if (c_q.size() == 0) begin
                chk("c_extra_word", 32'd1, 32'd0);
            end else begin
                c_exp = c_q.pop_front();
                chk("c_data", 32'(c_out_data), 32'(c_exp[7:0]));
                chk("c_last", 32'(c_out_last), 32'(c_exp[8]));
                chk("c_keep", 32'(c_out_keep), 32'd1);
                c_recv++;
            end
        end
    end

    initial begin
        int c_sent;
        int cyc;
        reset = 1'b1;
        a_drive(0, 8'h00, 0); b_drive(0, 8'h00, 0);
        c_in_valid = 0; c_in_data = 8'h00; c_in_last = 0;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        tick(); tick();

        // Reset state
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_keep",  32'(a_out_keep),  32'd0);
        chk("rst_a_last",  32'(a_out_last),  32'd0);
        chk("rst_a_data",  32'(a_out_data),  32'h000000);
        chk("rst_b_data",  32'(b_out_data),  32'hEEEEEE);
        chk("rst_c_valid", 32'(c_out_valid), 32'd0);
        reset = 1'b0;
        tick();

        // 1: 01..05(last), LSB-first
        a_drive(1, 8'h01, 0); tick();
        chk("t1_no_word_early", 32'(a_out_valid), 32'd0);
        a_drive(1, 8'h02, 0); tick();
        a_drive(1, 8'h03, 0); tick();
        chk_word("t1_w0", a_out_valid, a_out_data, a_out_keep, a_out_last, 24'h030201, 3'b111, 1'b0);
        a_drive(1, 8'h04, 0); tick();
        chk("t1_drained", 32'(a_out_valid), 32'd0);
        a_drive(1, 8'h05, 1); tick();
        chk_word("t1_w1", a_out_valid, a_out_data, a_out_keep, a_out_last, 24'h000504, 3'b011, 1'b1);
        a_drive(0, 8'h00, 0); tick();
        chk("t1_idle", 32'(a_out_valid), 32'd0);

        // 2: same stream, MSB-first with pad EE
        b_drive(1, 8'h01, 0); tick();
        b_drive(1, 8'h02, 0); tick();
        b_drive(1, 8'h03, 0); tick();
        chk_word("t2_w0", b_out_valid, b_out_data, b_out_keep, b_out_last, 24'h010203, 3'b111, 1'b0);
        b_drive(1, 8'h04, 0); tick();
        b_drive(1, 8'h05, 1); tick();
        chk_word("t2_w1", b_out_valid, b_out_data, b_out_keep, b_out_last, 24'h0405EE, 3'b011, 1'b1);
        b_drive(0, 8'h00, 0); tick();

        // 3: downstream stall for 10 cycles after the first word
        a_drive(1, 8'h01, 0); tick();
        a_drive(1, 8'h02, 0); tick();
        a_out_ready = 0;
        a_drive(1, 8'h03, 0); tick();
        a_drive(1, 8'h04, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_in_ready_held", 32'(a_in_ready), 32'd0);
            chk("t3_data_stable",   32'(a_out_data), 32'h030201);
            chk("t3_valid_held",    32'(a_out_valid), 32'd1);
            tick();
        end
        a_out_ready = 1;
        #1;
        chk("t3_in_ready_release", 32'(a_in_ready), 32'd1);
        tick();
        chk("t3_after_release", 32'(a_out_valid), 32'd0);
        a_drive(1, 8'h05, 1); tick();
        chk_word("t3_w1", a_out_valid, a_out_data, a_out_keep, a_out_last, 24'h000504, 3'b011, 1'b1);
        a_drive(0, 8'h00, 0); tick();

        // 4: single-item packet, then reset while that word is still held
        a_drive(1, 8'hAA, 1); tick();
        chk_word("t4_w0", a_out_valid, a_out_data, a_out_keep, a_out_last, 24'h0000AA, 3'b001, 1'b1);
        a_drive(0, 8'h00, 0);
        a_out_ready = 0; tick();
        chk("t4_held", 32'(a_out_valid), 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("t4_reset_drop", 32'(a_out_valid), 32'd0);
        a_out_ready = 1; tick();

        // 5: partial word discarded by reset
        a_drive(1, 8'h11, 0); tick();
        a_drive(1, 8'h22, 0); tick();
        a_drive(0, 8'h00, 0);
        reset = 1'b1; tick();
        reset = 1'b0;
        a_drive(1, 8'h33, 0); tick();
        chk("t5_no_word_33", 32'(a_out_valid), 32'd0);
        a_drive(1, 8'h44, 0); tick();
        chk("t5_no_word_44", 32'(a_out_valid), 32'd0);
        a_drive(1, 8'h55, 1); tick();
        chk_word("t5_w0", a_out_valid, a_out_data, a_out_keep, a_out_last, 24'h554433, 3'b111, 1'b1);
        a_drive(0, 8'h00, 0); tick();

        // 6: single-slot pass-through with random stalls on both sides
        c_sent = 0;
        c_fired = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (c_sent == C_ITEMS && c_q.size() == 0 && !c_out_valid) break;
            tick();
            if (c_in_valid && c_fired) begin
                c_in_valid = 0;
                c_fired = 1'b0;
                c_sent++;
            end
            if (!c_in_valid && c_sent < C_ITEMS && $urandom_range(0, 2) != 0) begin
                c_in_valid = 1;
                c_in_data  = 8'($urandom_range(0, 255));
                c_in_last  = ($urandom_range(0, 3) == 0);
            end
            c_out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("t6_timeout", 32'(cyc < 3000), 32'd1);
        chk("t6_recv_count", 32'(c_recv), 32'(C_ITEMS));
        chk("t6_leftover", 32'(c_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
